// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan
// Description : Time-multiplexed scanner for a common-anode 7-segment display
//               with frame-synchronous double-buffered display word.
//               Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int NUM_DIGITS   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [3:0]              nibble,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int c_cnt_w = $clog2(CLK_DIV);
    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_dw    = 4 * NUM_DIGITS;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_blank    = c_cnt_w'(BLANK_CYCLES);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);

    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_idx_w-1:0]    r_idx;
    logic [c_dw-1:0]       r_shadow;
    logic [c_dw-1:0]       r_pending;
    logic                  r_pend_valid;
    logic [3:0]            r_nibble;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_done;

    logic                  w_slot_end;
    logic                  w_boundary;
    logic [NUM_DIGITS-1:0] w_lit;
    logic [NUM_DIGITS-1:0] w_an_next;

    assign w_slot_end = (r_cnt == c_cnt_last);
    assign w_boundary = w_slot_end && (r_idx == c_idx_last);

`ifdef LEADING_ZERO_BLANK_EN
    logic w_acc;

    // Sweep from the top digit down: a digit is lit once any nibble at or
    // above it is nonzero. Digit 0 always lights so a zero word shows "0".
    always_comb begin
        w_acc = 1'b0;
        w_lit = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_acc    = w_acc | (r_shadow[4*i +: 4] != 4'h0);
            w_lit[i] = w_acc;
        end
        w_lit[0] = 1'b1;
    end
`else
    assign w_lit = '1;
`endif

    always_comb begin
        w_an_next = '1;
        if ((r_cnt >= c_blank) && digit_en[r_idx] && w_lit[r_idx]) begin
            w_an_next[r_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_pending    <= '0;
            r_pend_valid <= 1'b0;
            r_nibble     <= 4'h0;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end

            // A load landing on the boundary itself goes straight to the
            // shadow word and supersedes anything still pending.
            if (w_boundary) begin
                if (load) begin
                    r_shadow <= data_in;
                end else if (r_pend_valid) begin
                    r_shadow <= r_pending;
                end
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pending    <= data_in;
                r_pend_valid <= 1'b1;
            end

            r_nibble     <= r_shadow[{r_idx, 2'b00} +: 4];
            r_an         <= w_an_next;
            r_frame_done <= w_boundary;
        end
    end

    assign nibble     = r_nibble;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan
// Description : Randomised self-checking bench for seg_scan against a
//               cycle-count based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan;

    localparam int CLK_DIV = 4;
    localparam int BLANK   = 1;
    localparam int ND      = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] data_in;
    logic [7:0]  digit_en;
    logic [3:0]  nibble;
    logic [7:0]  an;
    logic        frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: time since reset plus the word buffers.
    int          m_t;
    logic [31:0] m_shadow;
    logic [31:0] m_pending;
    bit          m_pv;

    seg_scan #(
        .CLK_DIV     (CLK_DIV),
        .BLANK_CYCLES(BLANK),
        .NUM_DIGITS  (ND)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .load      (load),
        .digit_en  (digit_en),
        .nibble    (nibble),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    function automatic bit m_boundary();
        return ((m_t % CLK_DIV) == CLK_DIV - 1) && (((m_t / CLK_DIV) % ND) == ND - 1);
    endfunction

    function automatic bit lit(input int d);
`ifdef LEADING_ZERO_BLANK_EN
        return (d == 0) || ((m_shadow >> (4 * d)) != 32'h0);
`else
        return 1'b1;
`endif
    endfunction

    // One clock: predict the registered outputs from the pre-edge model state
    // and inputs, advance the model, then compare after the edge.
    task automatic step();
        int          pos;
        int          idx;
        logic [7:0]  e_an;
        logic [3:0]  e_nib;
        logic        e_fd;
        pos   = m_t % CLK_DIV;
        idx   = (m_t / CLK_DIV) % ND;
        e_nib = 4'(m_shadow >> (4 * idx));
        e_an  = 8'hFF;
        if (pos >= BLANK && digit_en[idx] && lit(idx)) e_an = ~(8'h01 << idx);
        e_fd  = m_boundary();
        if (e_fd) begin
            if (load) m_shadow = data_in;
            else if (m_pv) m_shadow = m_pending;
            m_pv = 1'b0;
        end else if (load) begin
            m_pending = data_in;
            m_pv      = 1'b1;
        end
        m_t++;
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("nibble", 32'(nibble), 32'(e_nib));
        check("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic load_word(input logic [31:0] w);
        data_in = w;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    task automatic wait_boundary();
        for (int k = 0; k < 4 * CLK_DIV * ND && !m_boundary(); k++) step();
    endtask

    // Asserts reset away from the clock edge and checks outputs clear at once.
    task automatic do_reset();
        load = 1'b0;
        rst  = 1'b1;
        #1;
        check("rst_an", 32'(an), 32'hFF);
        check("rst_nibble", 32'(nibble), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        m_t       = 0;
        m_shadow  = 32'h0;
        m_pending = 32'h0;
        m_pv      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        load     = 1'b0;
        data_in  = 32'h0;
        digit_en = 8'hFF;
        #3;
        do_reset();

        run(70);
        run(5);
        load_word(32'h89ABCDEF);
        run(70);
        run(3);
        load_word(32'h11111111);
        run(2);
        load_word(32'h22222222);
        run(70);
        wait_boundary();
        load_word(32'h00000055);
        run(40);
        digit_en = 8'hF0;
        run(40);
        digit_en = 8'hFF;
        load_word(32'h00000A05);
        run(70);
        load_word(32'h00000000);
        run(70);

        for (int k = 0; k < 800; k++) begin
            load    = ($urandom % 8 == 0);
            data_in = $urandom >> (4 * $urandom_range(0, 7));
            if ($urandom % 10 == 0) data_in = 32'h0;
            if ($urandom % 16 == 0) digit_en = 8'($urandom);
            step();
        end
        load     = 1'b0;
        digit_en = 8'hFF;

        load_word(32'hDEADBEEF);
        run(37);
        run(6);
        do_reset();
        run(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
